freq_meas_ctrl: RTL and testbench

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

---
 rtl/freq_meas_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl.sv
// Arbitrated controller that grants one of four requesters the frequency-counter datapath and runs a single gate per grant.
// Optional feature macro FREQ_AUTO_RANGE_EN: re-run a low-count first gate with a 10x longer gate.
module freq_meas_ctrl #(
    parameter logic [27:0] GATE_TIME = 28'd999_999,
    parameter int          SETTLE    = 16,
    parameter logic [27:0] RANGE_MIN = 28'd100
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic [3:0]  req,
    output logic [3:0]  grant,
    output logic [1:0]  ch_sel,
    output logic        meas_start,
    output logic [31:0] gate_len,
    input  logic        meas_done,
    input  logic [27:0] cnt_clk,
    input  logic [27:0] cnt_squ,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_ch,
    output logic [27:0] res_cntclk,
    output logic [27:0] res_cntsqu,
    output logic        res_timeout,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Result handshake: res_valid stays high with res_* frozen until a cycle where
    // res_valid && res_ready; the transfer happens on that edge and res_valid drops next cycle.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_e;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

`ifdef FREQ_AUTO_RANGE_EN
    localparam logic [35:0] GATE_X10  = 36'(GATE_TIME) * 36'd10;
    localparam logic [31:0] GATE_LONG = (GATE_X10 > 36'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : GATE_X10[31:0];
`endif

    state_e      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  ch_sel_q, ch_sel_d;
    logic        meas_start_q, meas_start_d;
    logic [31:0] gate_len_q, gate_len_d;
    logic        res_valid_q, res_valid_d;
    logic [1:0]  res_ch_q, res_ch_d;
    logic [27:0] res_cntclk_q, res_cntclk_d;
    logic [27:0] res_cntsqu_q, res_cntsqu_d;
    logic        res_timeout_q, res_timeout_d;
    logic        busy_q, busy_d;
    logic [33:0] wdog_q, wdog_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [1:0]  last_q, last_d;
`ifdef FREQ_AUTO_RANGE_EN
    logic        second_q, second_d;
`endif

    logic        rr_hit;
    logic [1:0]  rr_idx;
    logic [1:0]  rr_cand;
    logic [33:0] wd_limit;
    logic [33:0] wdog_nx;

    // Search starts one past the last owner, so the last owner is checked last.
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = last_q;
        rr_cand = '0;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = last_q + 2'(k);
            if (!rr_hit && req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    assign wd_limit = {gate_len_q, 2'b00} + 34'd64;
    assign wdog_nx  = wdog_q + 34'd1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ch_sel_d      = ch_sel_q;
        meas_start_d  = 1'b0;
        gate_len_d    = gate_len_q;
        res_valid_d   = res_valid_q;
        res_ch_d      = res_ch_q;
        res_cntclk_d  = res_cntclk_q;
        res_cntsqu_d  = res_cntsqu_q;
        res_timeout_d = res_timeout_q;
        wdog_d        = wdog_q;
        settle_cnt_d  = settle_cnt_q;
        last_d        = last_q;
`ifdef FREQ_AUTO_RANGE_EN
        second_d      = second_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) state_d = S_ARB;
            end
            S_ARB: begin
                if (rr_hit) begin
                    grant_d      = 4'b0001 << rr_idx;
                    ch_sel_d     = rr_idx;
                    last_d       = rr_idx;
                    gate_len_d   = {4'b0000, GATE_TIME};
                    settle_cnt_d = '0;
`ifdef FREQ_AUTO_RANGE_EN
                    second_d     = 1'b0;
`endif
                    if (SETTLE == 0) begin
                        state_d      = S_START;
                        meas_start_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    // Request vanished between IDLE and ARB: nothing to serve.
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = S_START;
                    meas_start_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (meas_done) begin
`ifdef FREQ_AUTO_RANGE_EN
                    if (!second_q && (cnt_squ < RANGE_MIN)) begin
                        gate_len_d   = GATE_LONG;
                        second_d     = 1'b1;
                        state_d      = S_START;
                        meas_start_d = 1'b1;
                    end else begin
                        res_ch_d      = ch_sel_q;
                        res_cntclk_d  = cnt_clk;
                        res_cntsqu_d  = cnt_squ;
                        res_timeout_d = 1'b0;
                        res_valid_d   = 1'b1;
                        state_d       = S_RESULT;
                    end
`else
                    res_ch_d      = ch_sel_q;
                    res_cntclk_d  = cnt_clk;
                    res_cntsqu_d  = cnt_squ;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = S_RESULT;
`endif
                end else if (wdog_nx == wd_limit) begin
                    res_ch_d      = ch_sel_q;
                    res_cntclk_d  = '0;
                    res_cntsqu_d  = '0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = S_RESULT;
                end else begin
                    wdog_d = wdog_nx;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    grant_d     = 4'b0000;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            ch_sel_q      <= '0;
            meas_start_q  <= 1'b0;
            gate_len_q    <= '0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_cntclk_q  <= '0;
            res_cntsqu_q  <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            wdog_q        <= '0;
            settle_cnt_q  <= '0;
            last_q        <= 2'd3;
`ifdef FREQ_AUTO_RANGE_EN
            second_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ch_sel_q      <= ch_sel_d;
            meas_start_q  <= meas_start_d;
            gate_len_q    <= gate_len_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_cntclk_q  <= res_cntclk_d;
            res_cntsqu_q  <= res_cntsqu_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            wdog_q        <= wdog_d;
            settle_cnt_q  <= settle_cnt_d;
            last_q        <= last_d;
`ifdef FREQ_AUTO_RANGE_EN
            second_q      <= second_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign ch_sel      = ch_sel_q;
    assign meas_start  = meas_start_q;
    assign gate_len    = gate_len_q;
    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_cntclk  = res_cntclk_q;
    assign res_cntsqu  = res_cntsqu_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with a short gate (GATE_TIME=100) so timeouts fit a brief run.
module tb_freq_meas_ctrl;

    localparam logic [27:0] GT     = 28'd100;
    localparam int          ST     = 16;
    localparam int          WD_CYC = 4 * 100 + 64;

    logic        clk_100M;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  ch_sel;
    logic        meas_start;
    logic [31:0] gate_len;
    logic        meas_done;
    logic [27:0] cnt_clk;
    logic [27:0] cnt_squ;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_ch;
    logic [27:0] res_cntclk;
    logic [27:0] res_cntsqu;
    logic        res_timeout;
    logic        busy;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [58:0] exp_q[$];

    freq_meas_ctrl #(
        .GATE_TIME (GT),
        .SETTLE    (ST),
        .RANGE_MIN (28'd100)
    ) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .ch_sel      (ch_sel),
        .meas_start  (meas_start),
        .gate_len    (gate_len),
        .meas_done   (meas_done),
        .cnt_clk     (cnt_clk),
        .cnt_squ     (cnt_squ),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ch      (res_ch),
        .res_cntclk  (res_cntclk),
        .res_cntsqu  (res_cntsqu),
        .res_timeout (res_timeout),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock and run limit
    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    initial begin
        #500_000;
        $display("FAIL sim_limit: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100M);
    endtask

    function automatic bit probe(input int which);
        case (which)
            0:       return grant != 4'b0000;
            1:       return meas_start;
            default: return res_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        while (!probe(which) && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("wait%0d_seen", which), 64'(probe(which)), 64'd1);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        repeat (3) tick();
        check({tag, "_grant"},    64'(grant), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_gate_len"}, 64'(gate_len), 64'd0);
        check({tag, "_outs"}, 64'({ch_sel, meas_start, res_valid, res_ch, res_cntclk, res_cntsqu, res_timeout}), 64'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_done(input logic [27:0] c, input logic [27:0] s);
        meas_done = 1'b1;
        cnt_clk   = c;
        cnt_squ   = s;
        tick();
        meas_done = 1'b0;
        cnt_clk   = '0;
        cnt_squ   = '0;
    endtask

    // Scoreboard: compare presented result against the oldest expected one
    task automatic sb_check(input string tag);
        logic [58:0] e;
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'({res_ch, res_cntclk, res_cntsqu, res_timeout}), 64'(e));
        end
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
        check({tag, "_grant_clr"},  64'(grant), 64'd0);
    endtask

    task automatic serve(input int idx, input logic [27:0] c, input logic [27:0] s, input string tag);
        int n;
        logic [3:0] g;
        g = 4'b0001 << idx;
        wait_for(0, 10, n);
        check({tag, "_grant"}, 64'(grant), 64'(g));
        check({tag, "_ch_sel"}, 64'(ch_sel), 64'(idx));
        exp_q.push_back({2'(idx), c, s, 1'b0});
        wait_for(1, 40, n);
        check({tag, "_settle"}, 64'(n), 64'(ST));
        tick();
        check({tag, "_start_pulse"}, 64'(meas_start), 64'd0);
        repeat (5) tick();
        drive_done(c, s);
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        sb_check(tag);
        accept(tag);
    endtask

    initial begin
        int  n;
        bit  stable;
        bit  started;
        logic [58:0] snap;

        rst_n     = 1'b0;
        req       = '0;
        meas_done = 1'b0;
        cnt_clk   = '0;
        cnt_squ   = '0;
        res_ready = 1'b0;
        apply_reset("rst0");

        // Single requester on channel 1; req drops mid-measurement
        req = 4'b0010;
        wait_for(0, 10, n);
        check("t1_grant", 64'(grant), 64'b0010);
        check("t1_ch_sel", 64'(ch_sel), 64'd1);
        check("t1_gate_len", 64'(gate_len), 64'(GT));
        check("t1_busy", 64'(busy), 64'd1);
        req = 4'b0000;
        wait_for(1, 40, n);
        check("t1_settle", 64'(n), 64'(ST));
        exp_q.push_back({2'd1, 28'd1_000_000, 28'd50_000, 1'b0});
        repeat (100) tick();
        check("t1_no_early_valid", 64'(res_valid), 64'd0);
        drive_done(28'd1_000_000, 28'd50_000);
        check("t1_valid", 64'(res_valid), 64'd1);
        sb_check("t1");
        accept("t1");
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Round robin with all requesters held, from a fresh pointer
        apply_reset("rst1");
        req = 4'b1111;
        serve(0, 28'd1000, 28'd11,  "rr0");
        serve(1, 28'd2000, 28'd22,  "rr1");
        serve(2, 28'd3000, 28'd33,  "rr2");
        req = 4'b1111;
        serve(3, 28'd4000, 28'd44,  "rr3");
        req = 4'b0000;
        tick();
        req = 4'b1111;
        serve(0, 28'd5000, 28'd55,  "rr4");
        req = 4'b0000;
        tick();

        // Watchdog timeout, then 100 cycles of back-pressure with a stray meas_done
        req = 4'b0001;
        wait_for(0, 10, n);
        check("t3_grant", 64'(grant), 64'b0001);
        req = 4'b0000;
        wait_for(1, 40, n);
        exp_q.push_back({2'd0, 28'd0, 28'd0, 1'b1});
        wait_for(2, 1000, n);
        check("t3_timeout_cycles", 64'(n), 64'(WD_CYC + 1));
        check("t3_timeout_flag", 64'(res_timeout), 64'd1);
        sb_check("t3");
        snap    = {res_ch, res_cntclk, res_cntsqu, res_timeout};
        stable  = 1'b1;
        started = 1'b0;
        for (int i = 0; i < 100; i++) begin
            meas_done = (i == 50);
            cnt_clk   = (i == 50) ? 28'h123 : 28'd0;
            cnt_squ   = (i == 50) ? 28'h456 : 28'd0;
            tick();
            if ({res_ch, res_cntclk, res_cntsqu, res_timeout} !== snap || res_valid !== 1'b1) stable = 1'b0;
            if (meas_start !== 1'b0) started = 1'b1;
        end
        meas_done = 1'b0;
        cnt_clk   = '0;
        cnt_squ   = '0;
        check("t3_hold_stable", 64'(stable), 64'd1);
        check("t3_hold_no_start", 64'(started), 64'd0);
        accept("t3");

        // Reset in WAIT discards the measurement; late meas_done is ignored
        req = 4'b0100;
        wait_for(0, 10, n);
        check("t4_grant", 64'(grant), 64'b0100);
        wait_for(1, 40, n);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_grant", 64'(grant), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_gate_len", 64'(gate_len), 64'd0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        drive_done(28'd777, 28'd55);
        repeat (3) tick();
        check("t4_no_valid", 64'(res_valid), 64'd0);
        check("t4_res_zero", 64'({res_ch, res_cntclk, res_cntsqu, res_timeout}), 64'd0);
        check("t4_state_idle", 64'(state_dbg), 64'd0);

        // Low square count on the first gate
        req = 4'b1000;
        wait_for(0, 10, n);
        check("t5_grant", 64'(grant), 64'b1000);
        req = 4'b0000;
        wait_for(1, 40, n);
        check("t5_gate_len1", 64'(gate_len), 64'(GT));
        repeat (5) tick();
        drive_done(28'd500, 28'd40);
`ifdef FREQ_AUTO_RANGE_EN
        check("t5_hidden", 64'(res_valid), 64'd0);
        check("t5_restart", 64'(meas_start), 64'd1);
        check("t5_gate_len2", 64'(gate_len), 64'd1000);
        exp_q.push_back({2'd3, 28'd5000, 28'd40, 1'b0});
        repeat (6) tick();
        drive_done(28'd5000, 28'd40);
`else
        exp_q.push_back({2'd3, 28'd500, 28'd40, 1'b0});
        check("t5_gate_len_fixed", 64'(gate_len), 64'(GT));
`endif
        check("t5_valid", 64'(res_valid), 64'd1);
        sb_check("t5");
        accept("t5");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
